// File: rtl/ewb_drain.sv
// Drain engine for the L2 eviction write buffer: bursts the head dirty line
// to memory beat by beat and pops it only once the final beat is acknowledged.
module ewb_drain #(
  parameter int width       = 256,
  parameter int burst_width = 64,
  parameter int beats       = 4,
  parameter int cnt_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ewb_empty_i,
  input  logic                   ewb_full_i,
  input  logic [width-1:0]       ewb_data_i,
  input  logic [31:0]            ewb_addr_i,
  output logic                   ewb_yumi_o,
  input  logic                   miss_pending_i,
  output logic                   busy_o,
  output logic [31:0]            mem_address_o,
  output logic                   mem_write_o,
  output logic [burst_width-1:0] mem_burst_o,
  input  logic                   mem_resp_i,
  output logic [cnt_width-1:0]   drained_count_o
);

  localparam int bw = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [bw-1:0] last_beat = bw'(beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [bw-1:0]   beat;
  logic [bw-1:0]   beat_next;
  logic [width-1:0] line;
  logic            start;

  // Reads win the port unless the buffer is full and must make room.
  assign start     = !ewb_empty_i && (!miss_pending_i || ewb_full_i);
  assign beat_next = beat + 1'b1;
  assign busy_o    = (state != IDLE);

  // Drain FSM; every memory/buffer output is a flop updated on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= '0;
      line            <= '0;
      mem_address_o   <= 32'd0;
      mem_write_o     <= 1'b0;
      mem_burst_o     <= '0;
      ewb_yumi_o      <= 1'b0;
      drained_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ewb_yumi_o <= 1'b0;
          if (start) begin
            // Line is captured so later enqueues cannot disturb the burst.
            line          <= ewb_data_i;
            mem_address_o <= {ewb_addr_i[31:5], 5'd0};
            mem_burst_o   <= ewb_data_i[burst_width-1:0];
            mem_write_o   <= 1'b1;
            beat          <= '0;
            state         <= WRITE;
          end else begin
            mem_write_o <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_resp_i) begin
            beat <= beat_next;
            if (beat == last_beat) begin
              mem_write_o   <= 1'b0;
              mem_address_o <= 32'd0;
              mem_burst_o   <= '0;
              ewb_yumi_o    <= 1'b1;
              state         <= DONE;
            end else begin
              mem_burst_o <= line[beat_next*burst_width +: burst_width];
            end
          end else begin
            mem_write_o <= 1'b1;
          end
        end
        DONE: begin
          ewb_yumi_o      <= 1'b0;
          drained_count_o <= drained_count_o + 1'b1;
          state           <= IDLE;
        end
        default: begin
          mem_write_o   <= 1'b0;
          mem_address_o <= 32'd0;
          mem_burst_o   <= '0;
          ewb_yumi_o    <= 1'b0;
          beat          <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ewb_drain.md
Name: ewb_drain

Overview:
Consumer end of the L2 eviction write buffer. It takes the head dirty line from the buffer's valid-yumi output and writes it to physical memory as a burst of 64-bit beats. It pops the entry only after the last beat is acknowledged, so tag checks against the buffer still hit while the write is in flight. It yields the memory port to pending L2 read misses unless the buffer is full.

Parameters:
width, 256, cache line width in bits
burst_width, 64, memory beat width in bits
beats, 4, beats per line (width/burst_width); beat counter is clog2(beats) bits
cnt_width, 16, width of drained-line counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ewb_empty_i  in  1  write buffer empty (head invalid)
ewb_full_i  in  1  write buffer full
ewb_data_i  in  width  head line data
ewb_addr_i  in  32  head line address
ewb_yumi_o  out  1  pop head; one-cycle pulse
miss_pending_i  in  1  L2 read miss owns/wants memory; held for whole read transaction
busy_o  out  1  drain owns memory port
mem_address_o  out  32  line address, bits [4:0] forced 0
mem_write_o  out  1  memory write request
mem_burst_o  out  burst_width  current beat data
mem_resp_i  in  1  memory accepted current beat
drained_count_o  out  cnt_width  lines fully written since reset

Behaviour:
- One clock, clk. rst is synchronous and active-high: at a rst edge, state=IDLE, beat=0, latched line/address=0, drained_count_o=0. All outputs read 0 in the cycle after reset.
- State machine, registered: IDLE, WRITE, DONE.
- start = !ewb_empty_i && (!miss_pending_i || ewb_full_i).
  - Reads have priority.
  - A full buffer forces a drain, and the read waits.
- IDLE:
  - All outputs 0 except drained_count_o.
  - On start: latch ewb_data_i, and ewb_addr_i with bits [4:0] cleared; beat<=0; next state WRITE.
- WRITE:
  - busy_o=1, mem_write_o=1, mem_address_o=latched address.
  - mem_burst_o = latched line[beat*burst_width +: burst_width]; beat 0 is the LSBs.
  - On mem_resp_i: beat<=beat+1. If beat==beats-1, next state DONE.
  - Without mem_resp_i: hold all outputs stable indefinitely.
  - Non-preemptible: miss_pending_i and ewb_full_i are ignored.
- DONE:
  - busy_o=1, mem_write_o=0, ewb_yumi_o=1 for exactly this cycle.
  - drained_count_o increments; it wraps modulo 2^cnt_width.
  - Next state IDLE.
- Minimum line latency: start cycle to yumi = beats+1 cycles, with resp every cycle.
- Earliest next start is the cycle after DONE. busy_o drops for at least one IDLE cycle between lines, giving the read arbiter a window.
- ewb_yumi_o is never asserted while ewb_empty_i=1, and never outside DONE.
- mem_resp_i in IDLE or DONE is ignored: no beat or state change.
- Data is latched, so buffer enqueues during a drain cannot corrupt the burst.
- Reset mid-WRITE: abort immediately, no yumi, no count increment. Memory-side cleanup is owned by the memory model.
- busy_o = (state != IDLE), combinational from state.

Test Plan:
- Single line: ewb_addr_i=0x0000_1234, data beats D0..D3 = 0x11..11, 0x22..22, 0x33..33, 0x44..44; resp every cycle -> mem_address_o=0x0000_1220; bursts in order D0..D3; yumi pulses once 5 cycles after start; drained_count_o=1.
- Read priority: buffer non-empty with miss_pending_i=1, ewb_full_i=0 for 10 cycles -> mem_write_o=0 throughout. Lower miss_pending_i -> WRITE entered next cycle.
- Forced drain: miss_pending_i=1, ewb_full_i=1 -> drain starts. Raising miss_pending_i mid-WRITE does not stop the burst.
- Backpressure: mem_resp_i low for 7 cycles on beat 2 -> mem_burst_o holds D2 and mem_address_o is stable; completion follows with exactly one yumi.
- Back-to-back: 3 lines queued, resp always 1 -> exactly 3 yumi pulses, one IDLE cycle between lines, drained_count_o=3. Stray mem_resp_i in IDLE -> no effect.
- Reset mid-beat 1 -> next cycle state IDLE, mem_write_o=0, no yumi, drained_count_o=0.
